// File: rtl/cpu_pkg.sv
// Shared types and defaults for the memory controller slice.
package cpu_pkg;

  localparam int unsigned AW_DEF   = 8;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned WAIT_DEF = 2;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Even-parity bit: makes the total count of ones (data + parity) even
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port memory with synchronous write and registered read.
// MEM_PARITY_EN widens each word by one even-parity bit and reports mismatches on reads.
module mem_array
  import cpu_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic          i_clr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_perr
);

`ifdef MEM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif
  localparam int unsigned DEPTH = 1 << AW;

  logic [MW-1:0] r_mem [DEPTH];
  logic [MW-1:0] w_wword;
  logic [MW-1:0] w_rword;
  logic          w_rd_perr;
  logic [DW-1:0] r_rdata;
  logic          r_perr;

`ifdef MEM_PARITY_EN
  assign w_wword   = {even_par(64'(i_wdata)), i_wdata};
  assign w_rd_perr = ^w_rword;
`else
  assign w_wword   = i_wdata;
  assign w_rd_perr = 1'b0;
`endif

  assign w_rword = r_mem[i_addr];

  // Array contents survive reset
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= w_wword;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
      r_perr  <= 1'b0;
    end else if (i_re) begin
      r_rdata <= w_rword[DW-1:0];
      r_perr  <= w_rd_perr;
    end else if (i_clr) begin
      r_perr  <= 1'b0;
    end
  end

  assign o_rdata = r_rdata;
  assign o_perr  = r_perr;

endmodule

// File: rtl/mem_ctrl.sv
// Handshaked main-memory controller: request latch, programmable wait states, MFC handshake.
// Optional MEM_PARITY_EN adds per-word even parity and the perr flag.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          enable,
  input  logic          rnw,
  input  logic [AW-1:0] MAR,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          MFC,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic          perr
);

  localparam logic NO_WAIT = (WAIT_CYCLES == 0);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic             r_rnw;
  logic             r_mfc;

  logic             w_idle;
  logic             w_accept;
  logic             w_access;
  logic             w_load;
  logic             w_acc_rnw;
  logic [AW-1:0]    w_acc_addr;
  logic [DW-1:0]    w_acc_data;
  logic             w_we;
  logic             w_re;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;

  // With zero wait states the access happens on the accept edge, so use the live request inputs
  assign w_idle     = (r_state == IDLE);
  assign w_accept   = w_idle & enable;
  assign w_access   = (w_accept & NO_WAIT) | ((r_state == WAIT) & (r_cnt == CNT_W'(1)));
  assign w_load     = w_idle & ~enable & prog_we;
  assign w_acc_rnw  = w_idle ? rnw   : r_rnw;
  assign w_acc_addr = w_idle ? MAR   : r_addr;
  assign w_acc_data = w_idle ? wdata : r_wdata;
  assign w_we       = (w_access & ~w_acc_rnw) | w_load;
  assign w_re       = w_access & w_acc_rnw;
  assign w_addr     = w_load ? prog_addr : w_acc_addr;
  assign w_wdata    = w_load ? prog_data : w_acc_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rnw   <= 1'b0;
      r_mfc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_addr  <= MAR;
            r_wdata <= wdata;
            r_rnw   <= rnw;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            if (NO_WAIT) begin
              r_state <= DONE;
              r_mfc   <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_mfc   <= 1'b1;
          end
        end
        DONE: begin
          // Four-phase handshake: stay here until the requester drops enable
          if (!enable) begin
            r_state <= IDLE;
            r_mfc   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_mfc   <= 1'b0;
        end
      endcase
    end
  end

  assign MFC = r_mfc;

  mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_clr   (w_accept),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (rdata),
    .o_perr  (perr)
  );

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Handshaked main-memory controller. It sits directly upstream of MBR and downstream of MAR and the control unit.
- Accepts a read or write request from CS_bus WMFC/rnw and latches the MAR address and bus data. It then inserts programmable wait states, performs the access and raises MFC.
- The control unit stalls its microstep until MFC is seen. Read data drives MBR's input.

Parameters:
- AW, 8: address width; memory depth is 2**AW words.
- DW, 8: data width.
- WAIT_CYCLES, 2: wait states between request acceptance and access. Range 0..15.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous active-high reset.
- enable  input  1  request (CS_bus[WMFC]); held high until MFC is seen.
- rnw  input  1  1 = read, 0 = write; sampled with the request.
- MAR  input  AW  access address; sampled with the request.
- wdata  input  DW  write data from the system bus; sampled with the request.
- rdata  output  DW  read data to MBR input.
- MFC  output  1  memory function complete.
- prog_we  input  1  bench/boot loader write strobe.
- prog_addr  input  AW  loader address.
- prog_data  input  DW  loader data.
- perr  output  1  parity error flag (see Optional Feature).

Behaviour:
- Reset (async, RST=1): state=IDLE, MFC=0, rdata=0, perr=0, wait counter=0, latched address/data/rnw=0. Memory array contents are not affected by reset.
- States: IDLE, WAIT, DONE.
- IDLE, enable=1 at edge: latch MAR, rnw, wdata; load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0.
  - Otherwise perform the access and go to DONE.
- WAIT: counter decrements each edge. At the edge where counter==1: perform the access and go to DONE.
- Access:
  - Read: rdata <= mem[addr].
  - Write: mem[addr] <= wdata_latched; rdata unchanged.
- DONE: MFC=1 (registered; the high level itself is entered on the access edge).
  - Leave to IDLE at the first edge with enable=0; MFC falls on that edge.
  - While enable stays 1, hold DONE with no new access (four-phase handshake).
- Latency: MFC is high after WAIT_CYCLES+1 rising edges, counted from the edge that samples enable=1.
- Changes to MAR/rnw/wdata/enable after acceptance are ignored until return to IDLE.
- A new request needs enable low for at least one edge after MFC.
- enable dropping in WAIT is ignored: the access completes, then DONE returns to IDLE on the next edge since enable=0.
- Loader port: prog_we honoured only in IDLE with enable=0, writing mem[prog_addr] <= prog_data that edge.
  - If prog_we and enable are both 1 in IDLE, the request wins and the loader write is dropped.
  - prog_we in WAIT/DONE is dropped.
- Address is AW bits, so no out-of-range case exists. Address 2**AW-1 is a normal location; there is no wrap logic.
- Reset mid-operation: a WAIT-state write not yet committed is discarded. A committed write persists.

Optional Feature:
- Macro MEM_PARITY_EN.
- Defined:
  - Array stores DW+1 bits per word with even parity, generated on every write (request or loader).
  - On a read, perr is set with rdata and equals the parity mismatch.
  - perr clears on the next accepted request or on reset.
- Undefined: array is DW bits wide and perr is tied 0.

Decomposition:
- Shared package cpu_pkg: state enum (IDLE/WAIT/DONE), default AW/DW, WAIT_CYCLES default, parity helper function.
- Sub-module mem_array:
  - Synchronous single-port write, registered read, width DW or DW+1.
  - Arbitration between request and loader is done in mem_ctrl.

Test Plan:
- Reset then load mem[0x10]=0xA5 via loader. Read request at 0x10 with WAIT_CYCLES=2 -> MFC rises on the 3rd edge after acceptance, rdata=0xA5. MFC stays high until enable drops, then falls the next edge.
- Write 0x3C to 0xFF, then read 0xFF -> rdata=0x3C. Location 0x00 is unchanged (no wrap).
- WAIT_CYCLES=0: read accepted -> MFC=1 after exactly 1 edge.
- Change MAR from 0x10 to 0x20 during WAIT -> data from 0x10 is returned. Holding enable high in DONE -> no second access; a write issued this way commits once only.
- Assert RST during WAIT of a write of 0x77 to 0x05 (old 0x11) -> MFC=0, state IDLE, mem[0x05] still 0x11. prog_we together with enable in IDLE -> loader write dropped.
- MEM_PARITY_EN: force a parity-bit flip in mem_array at 0x08, then read -> perr=1. Next accepted request -> perr=0.
